// File: rtl/hazard_detect_unit.sv
// Pipeline hazard detector: decides when to stall the front end, inject a
// bubble into ID/EX, or flush IF/ID for a redirect, and counts stall cycles.
module hazard_detect_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ifid_r1,
    input  logic [4:0]  ifid_r2,
    input  logic        ifid_uses_r2,
    input  logic        ifid_branch,
    input  logic        ifid_jump,
    input  logic        branch_taken,
    input  logic [4:0]  idex_reg_rd,
    input  logic        idex_reg_write,
    input  logic        idex_mem_read,
    input  logic [4:0]  exmem_reg_rd,
    input  logic        exmem_mem_read,
    output logic        o_pc_write,
    output logic        o_ifid_write,
    output logic        o_idex_bubble,
    output logic        o_ifid_flush,
    output logic [15:0] o_stall_count
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic [15:0] stall_count_q;
    logic [15:0] stall_count_d;

    logic match_ex;
    logic match_mem;
    logic hazard_1;
    logic hazard_2;
    logic stall;

    // x0 is hardwired zero, so it can never be a real producer.
    function automatic logic reg_match(input logic [4:0] rd,
                                       input logic [4:0] r1,
                                       input logic [4:0] r2,
                                       input logic       uses_r2);
        return (rd != 5'd0) && ((rd == r1) || (uses_r2 && (rd == r2)));
    endfunction

    assign match_ex  = reg_match(idex_reg_rd,  ifid_r1, ifid_r2, ifid_uses_r2);
    assign match_mem = reg_match(exmem_reg_rd, ifid_r1, ifid_r2, ifid_uses_r2);

    // A branch reading a load still in EX needs the data two stages later.
    assign hazard_2 = ifid_branch && idex_mem_read && match_ex;

    assign hazard_1 = (idex_mem_read && match_ex)
                   || (ifid_branch && idex_reg_write && !idex_mem_read && match_ex)
                   || (ifid_branch && exmem_mem_read && match_mem);

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        unique case (state_q)
            IDLE: begin
                stall = hazard_1 || hazard_2;
                if (hazard_2) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                stall   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            stall_count_q <= stall_count_d;
        end
    end

    // A redirecting branch must not be flushed while it is itself stalled.
    assign o_pc_write    = !stall;
    assign o_ifid_write  = !stall;
    assign o_idex_bubble = stall;
    assign o_ifid_flush  = !stall && ((ifid_branch && branch_taken) || ifid_jump);
    assign o_stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Self-checking bench for hazard_detect_unit: directed scenarios with literal
// expectations, then random traffic against a remaining-stall-cycles model.
module tb_hazard_detect_unit;

    logic        clk;
    logic        rst_n;
    logic [4:0]  ifid_r1;
    logic [4:0]  ifid_r2;
    logic        ifid_uses_r2;
    logic        ifid_branch;
    logic        ifid_jump;
    logic        branch_taken;
    logic [4:0]  idex_reg_rd;
    logic        idex_reg_write;
    logic        idex_mem_read;
    logic [4:0]  exmem_reg_rd;
    logic        exmem_mem_read;
    logic        o_pc_write;
    logic        o_ifid_write;
    logic        o_idex_bubble;
    logic        o_ifid_flush;
    logic [15:0] o_stall_count;

    int checks   = 0;
    int failures = 0;

    // Model: cycles of forced stall still owed, and the stall total so far.
    int m_owed  = 0;
    int m_count = 0;

    hazard_detect_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ifid_r1        (ifid_r1),
        .ifid_r2        (ifid_r2),
        .ifid_uses_r2   (ifid_uses_r2),
        .ifid_branch    (ifid_branch),
        .ifid_jump      (ifid_jump),
        .branch_taken   (branch_taken),
        .idex_reg_rd    (idex_reg_rd),
        .idex_reg_write (idex_reg_write),
        .idex_mem_read  (idex_mem_read),
        .exmem_reg_rd   (exmem_reg_rd),
        .exmem_mem_read (exmem_mem_read),
        .o_pc_write     (o_pc_write),
        .o_ifid_write   (o_ifid_write),
        .o_idex_bubble  (o_idex_bubble),
        .o_ifid_flush   (o_ifid_flush),
        .o_stall_count  (o_stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit reads(input logic [4:0] rd);
        return rd != 0 && (rd == ifid_r1 || (ifid_uses_r2 && rd == ifid_r2));
    endfunction

    function automatic bit two_cycle_hazard();
        return ifid_branch && idex_mem_read && reads(idex_reg_rd);
    endfunction

    function automatic bit any_hazard();
        bit load_use, alu_branch, mem_branch;
        load_use   = idex_mem_read && reads(idex_reg_rd);
        alu_branch = ifid_branch && idex_reg_write && !idex_mem_read && reads(idex_reg_rd);
        mem_branch = ifid_branch && exmem_mem_read && reads(exmem_reg_rd);
        return load_use || alu_branch || mem_branch || two_cycle_hazard();
    endfunction

    function automatic bit model_stall();
        return (m_owed > 0) || any_hazard();
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_owed  <= 0;
            m_count <= 0;
        end else begin
            if (model_stall() && m_count < 65535) m_count <= m_count + 1;
            m_owed <= (m_owed > 0) ? 0 : (two_cycle_hazard() ? 1 : 0);
        end
    end

    always @(negedge clk) begin
        bit s;
        s = model_stall();
        chk("pc_write",    {31'd0, o_pc_write},    {31'd0, !s});
        chk("ifid_write",  {31'd0, o_ifid_write},  {31'd0, !s});
        chk("idex_bubble", {31'd0, o_idex_bubble}, {31'd0, s});
        chk("ifid_flush",  {31'd0, o_ifid_flush},
            {31'd0, !s && ((ifid_branch && branch_taken) || ifid_jump)});
        chk("stall_count", {16'd0, o_stall_count}, m_count);
    end

    task automatic clear_inputs();
        ifid_r1 = 0; ifid_r2 = 0; ifid_uses_r2 = 0; ifid_branch = 0;
        ifid_jump = 0; branch_taken = 0; idex_reg_rd = 0; idex_reg_write = 0;
        idex_mem_read = 0; exmem_reg_rd = 0; exmem_mem_read = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; the pulse ends well before the next one.
    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #12;
        chk("reset_count", {16'd0, o_stall_count}, 32'd0);
        chk("reset_pc_write", {31'd0, o_pc_write}, 32'd1);
        rst_n = 1'b1;

        // Load-use: one stall cycle.
        next();
        idex_mem_read = 1; idex_reg_rd = 5; ifid_r1 = 5;
        #2;
        chk("loaduse_pc_write", {31'd0, o_pc_write}, 32'd0);
        chk("loaduse_bubble", {31'd0, o_idex_bubble}, 32'd1);
        next();
        clear_inputs();
        #2;
        chk("loaduse_count", {16'd0, o_stall_count}, 32'd1);
        chk("loaduse_release", {31'd0, o_pc_write}, 32'd1);

        // Load in EX feeding a branch: two stall cycles.
        next();
        do_reset();
        next();
        ifid_branch = 1; ifid_r1 = 3; ifid_r2 = 7; ifid_uses_r2 = 1;
        idex_mem_read = 1; idex_reg_rd = 7;
        #2;
        chk("ldbr_stall1", {31'd0, o_pc_write}, 32'd0);
        next();
        clear_inputs();
        #2;
        chk("ldbr_stall2", {31'd0, o_idex_bubble}, 32'd1);
        next();
        #1;
        chk("ldbr_done", {31'd0, o_pc_write}, 32'd1);
        chk("ldbr_count", {16'd0, o_stall_count}, 32'd2);

        // x0 destination never stalls.
        next();
        idex_mem_read = 1; idex_reg_rd = 0; ifid_r1 = 0;
        #2;
        chk("x0_pc_write", {31'd0, o_pc_write}, 32'd1);

        // Taken branch with ALU hazard: no flush until its stall is over.
        next();
        clear_inputs();
        ifid_branch = 1; branch_taken = 1; idex_reg_write = 1; idex_reg_rd = 9; ifid_r1 = 9;
        #2;
        chk("flush_gated", {31'd0, o_ifid_flush}, 32'd0);
        chk("flush_gated_stall", {31'd0, o_pc_write}, 32'd0);
        next();
        idex_reg_write = 0;
        #2;
        chk("flush_after", {31'd0, o_ifid_flush}, 32'd1);

        // Reset while holding abandons the second stall cycle immediately.
        next();
        clear_inputs();
        do_reset();
        next();
        ifid_branch = 1; ifid_r1 = 4; idex_mem_read = 1; idex_reg_rd = 4;
        next();
        clear_inputs();
        #1;
        chk("hold_stalling", {31'd0, o_pc_write}, 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("hold_reset_count", {16'd0, o_stall_count}, 32'd0);
        chk("hold_reset_pc_write", {31'd0, o_pc_write}, 32'd1);
        #2;
        rst_n = 1'b1;

        // Random traffic with small register numbers so matches are frequent.
        for (int i = 0; i < 4000; i++) begin
            next();
            rst_n          = ($urandom_range(0, 99) != 0);
            ifid_r1        = 5'($urandom_range(0, 3));
            ifid_r2        = 5'($urandom_range(0, 3));
            ifid_uses_r2   = 1'($urandom);
            ifid_branch    = 1'($urandom);
            ifid_jump      = ($urandom_range(0, 7) == 0);
            branch_taken   = 1'($urandom);
            idex_reg_rd    = 5'($urandom_range(0, 3));
            idex_reg_write = 1'($urandom);
            idex_mem_read  = 1'($urandom);
            exmem_reg_rd   = 5'($urandom_range(0, 3));
            exmem_mem_read = 1'($urandom);
        end

        // Saturation: a sustained load-use hazard stalls every cycle.
        next();
        rst_n = 1'b1;
        clear_inputs();
        do_reset();
        idex_mem_read = 1; idex_reg_rd = 6; ifid_r1 = 6;
        repeat (65534) next();
        #1;
        chk("sat_preload", {16'd0, o_stall_count}, 32'h0000FFFE);
        repeat (3) next();
        #1;
        chk("sat_hold", {16'd0, o_stall_count}, 32'h0000FFFF);

        next();
        clear_inputs();
        #2;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
